// File: rtl/i2c_rtl_pkg.sv
// Shared types, widths and helpers for the I2C memory slave.
package i2c_rtl_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWaitStop
  } i2c_slv_state_t;

  function automatic bit is_power_of_2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus stability filter for one I2C line, with edge pulses
// that are high in the same cycle the filtered level takes its new value.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, then accept a new level only after FILTER_LEN stable cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) begin
          level_q <= sync_q[1];
          rise_q  <= sync_q[1];
          fall_q  <= ~sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C slave with a byte-addressed register file, auto-incrementing pointer and
// optional clock stretching after every acknowledge bit.
module i2c_mem_slave
  import i2c_rtl_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR     = 7'h22,
  parameter int unsigned           MEM_DEPTH      = 16,
  parameter int unsigned           FILTER_LEN     = 3,
  parameter int unsigned           STRETCH_CYCLES = 0,
  localparam int unsigned          PTR_W          = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic                  busy_o,
  output logic                  wr_stb_o,
  output logic [PTR_W-1:0]      wr_ptr_o,
  output logic [I2C_BYTE_W-1:0] wr_data_o
);

  localparam int unsigned SW = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;

  if (!is_power_of_2(MEM_DEPTH) || MEM_DEPTH < 2 || MEM_DEPTH > 256) begin : g_depth_check
    $error("MEM_DEPTH must be a power of 2 in 2..256");
  end

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // Edge pulses coincide with the new level, so scl_lvl here is the level during the sda edge.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_slv_state_t          state_q, state_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0]   shreg_q, shreg_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    rw_q, rw_d;
  logic                    sda_q, sda_d;
  logic                    busy_q, busy_d;
  logic                    nack_q, nack_d;
  logic [SW-1:0]           stretch_q, stretch_d;
  logic                    wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [I2C_BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic [I2C_BYTE_W-1:0]   mem_q [MEM_DEPTH];

  logic [I2C_BYTE_W-1:0] shifted;
  logic [I2C_BYTE_W-1:0] rd_byte;
  assign shifted = {shreg_q[I2C_BYTE_W-2:0], sda_lvl};
  assign rd_byte = mem_q[ptr_q];

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    nack_d    = nack_q;
    stretch_d = (stretch_q != '0) ? stretch_q - 1'b1 : '0;
    wr_stb_d  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    wr_data_d = wr_data_q;

    if (stop_det) begin
      state_d = StIdle;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      nack_d  = 1'b0;
    end else if (start_det) begin
      state_d   = StAddr;
      sda_d     = 1'b1;
      bit_cnt_d = '0;
      nack_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (shreg_q[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
              state_d = StAddrAck;
              sda_d   = 1'b0;
              busy_d  = 1'b1;
              rw_d    = shreg_q[0];
            end else begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            stretch_d = SW'(STRETCH_CYCLES);
            if (rw_q) begin
              state_d = StRdata;
              shreg_d = rd_byte;
              sda_d   = rd_byte[I2C_BYTE_W-1];
            end else begin
              state_d = StPtr;
              sda_d   = 1'b1;
            end
          end
        end
        StPtr: begin
          if (scl_rise) begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            ptr_d     = shreg_q[PTR_W-1:0];
            sda_d     = 1'b0;
            bit_cnt_d = '0;
            state_d   = StPtrAck;
          end
        end
        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            stretch_d = SW'(STRETCH_CYCLES);
            sda_d     = 1'b1;
            state_d   = StWdata;
          end
        end
        StWdata: begin
          if (scl_rise) begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              wr_stb_d  = 1'b1;
              wr_ptr_d  = ptr_q;
              wr_data_d = shifted;
              ptr_d     = ptr_q + 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_d     = 1'b0;
            bit_cnt_d = '0;
            state_d   = StWdataAck;
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_d     = 1'b1;
              bit_cnt_d = '0;
              ptr_d     = ptr_q + 1'b1;
              state_d   = StRdataAck;
            end else begin
              shreg_d   = shreg_q << 1;
              sda_d     = shreg_q[I2C_BYTE_W-2];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StRdataAck: begin
          // A NACK leaves the state on the rise, so a fall here always follows an ACK.
          if (scl_rise) begin
            if (sda_lvl) begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
              nack_d  = 1'b1;
            end
          end else if (scl_fall) begin
            stretch_d = SW'(STRETCH_CYCLES);
            shreg_d   = rd_byte;
            sda_d     = rd_byte[I2C_BYTE_W-1];
            bit_cnt_d = '0;
            state_d   = StRdata;
          end
        end
        StWaitStop: begin
          // Stretch once after the master's NACK bit, then ignore the bus.
          if (scl_fall && nack_q) begin
            stretch_d = SW'(STRETCH_CYCLES);
            nack_d    = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, datapath and register-file update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      nack_q    <= 1'b0;
      stretch_q <= '0;
      wr_stb_q  <= 1'b0;
      wr_ptr_q  <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_q     <= sda_d;
      busy_q    <= busy_d;
      nack_q    <= nack_d;
      stretch_q <= stretch_d;
      wr_stb_q  <= wr_stb_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_data_q <= wr_data_d;
      if (wr_stb_d) mem_q[wr_ptr_d] <= wr_data_d;
    end
  end

  assign scl_o     = (stretch_q == '0);
  assign sda_o     = sda_q;
  assign busy_o    = busy_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_ptr_o  = wr_ptr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench: a bit-banged I2C master on a wired-AND bus around i2c_mem_slave.
module tb_i2c_mem_slave;

  localparam int HALF    = 30;
  localparam int QTR     = 15;
  localparam int STRETCH = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_o, sda_o, busy, wr_stb;
  logic [3:0] wr_ptr;
  logic [7:0] wr_data;

  wire scl_bus = scl_m & scl_o;
  wire sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_mem_slave #(
    .SLAVE_ADDR    (7'h22),
    .MEM_DEPTH     (16),
    .FILTER_LEN    (3),
    .STRETCH_CYCLES(STRETCH)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .scl_i    (scl_bus),
    .sda_i    (sda_bus),
    .scl_o    (scl_o),
    .sda_o    (sda_o),
    .busy_o   (busy),
    .wr_stb_o (wr_stb),
    .wr_ptr_o (wr_ptr),
    .wr_data_o(wr_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Monitors: write strobes, slave line activity, scl_o low-pulse lengths.
  int          stb_cnt = 0;
  logic [11:0] stb_log [$];
  int          drv_cnt = 0;
  int          low_run = 0;
  int          last_low = 0;
  int          odd_runs = 0;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_log.push_back({wr_ptr, wr_data});
      stb_cnt++;
    end
    if (sda_o === 1'b0 || scl_o === 1'b0) drv_cnt++;
    if (scl_o === 1'b0) begin
      low_run++;
    end else begin
      if (low_run != 0) begin
        last_low = low_run;
        if (low_run != STRETCH) odd_runs++;
      end
      low_run = 0;
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: cycles=150000 required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl_bus !== 1'b1 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scl_release: scl=%b required=1 within 2000 cycles", scl_bus);
    end
  endtask

  // START, or repeated START when called with scl low.
  task automatic m_start();
    sda_m = 1'b1; clk_n(QTR);
    scl_m = 1'b1; wait_scl_high(); clk_n(HALF);
    sda_m = 1'b0; clk_n(HALF);
    scl_m = 1'b0; clk_n(QTR);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; clk_n(QTR);
    scl_m = 1'b1; wait_scl_high(); clk_n(HALF);
    sda_m = 1'b1; clk_n(HALF);
  endtask

  task automatic m_bit(input logic b, output logic s);
    sda_m = b; clk_n(QTR);
    scl_m = 1'b1; wait_scl_high(); clk_n(HALF / 2);
    s = sda_bus; clk_n(HALF / 2);
    scl_m = 1'b0; clk_n(QTR);
  endtask

  // ack returns the bus level of the 9th bit: 0 = ACK.
  task automatic m_write(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(nack, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_n(5);
    @(negedge clk);
    n_cmp++; if (scl_o !== 1'b1) begin n_bad++; $display("FAIL rst_scl: got %b want 1", scl_o); end
    n_cmp++; if (sda_o !== 1'b1) begin n_bad++; $display("FAIL rst_sda: got %b want 1", sda_o); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (wr_stb !== 1'b0) begin n_bad++; $display("FAIL rst_stb: got %b want 0", wr_stb); end
    n_cmp++; if (wr_ptr !== 4'h0) begin n_bad++; $display("FAIL rst_ptr: got %h want 0", wr_ptr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", wr_data); end
    rst = 1'b0;
    clk_n(10);
  endtask

  task automatic test_write();
    int   b0 = stb_cnt;
    logic a0, a1, a2, a3;
    m_start();
    m_write(8'h44, a0);
    m_write(8'h03, a1);
    m_write(8'hA5, a2);
    m_write(8'h5A, a3);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
    m_stop();
    clk_n(10);
    @(negedge clk);
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin
      n_bad++; $display("FAIL wr_acks: got %b want 0000", {a0, a1, a2, a3});
    end
    n_cmp++; if (stb_cnt - b0 != 2) begin n_bad++; $display("FAIL wr_stb_count: got %0d want 2", stb_cnt - b0); end
    n_cmp++; if (stb_log[b0] !== 12'h3A5) begin n_bad++; $display("FAIL wr_stb0: got %h want 3a5", stb_log[b0]); end
    n_cmp++; if (stb_log[b0+1] !== 12'h45A) begin n_bad++; $display("FAIL wr_stb1: got %h want 45a", stb_log[b0+1]); end
    n_cmp++; if ({wr_ptr, wr_data} !== 12'h45A) begin
      n_bad++; $display("FAIL wr_hold: got %h want 45a", {wr_ptr, wr_data});
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    n_cmp++; if (last_low != STRETCH) begin n_bad++; $display("FAIL stretch_len: got %0d want %0d", last_low, STRETCH); end
  endtask

  task automatic test_read();
    int         b0 = stb_cnt;
    logic       a0, a1, a2;
    logic [7:0] d0, d1, d2;
    m_start();
    m_write(8'h44, a0);
    m_write(8'h03, a1);
    m_start();
    m_write(8'h45, a2);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy_mid: got %b want 1", busy); end
    m_read(1'b0, d0);
    m_read(1'b0, d1);
    m_read(1'b1, d2);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_nack: got %b want 0", busy); end
    m_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (d0 !== 8'hA5) begin n_bad++; $display("FAIL rd_byte0: got %h want a5", d0); end
    n_cmp++; if (d1 !== 8'h5A) begin n_bad++; $display("FAIL rd_byte1: got %h want 5a", d1); end
    n_cmp++; if (d2 !== 8'h00) begin n_bad++; $display("FAIL rd_byte2: got %h want 00", d2); end
    n_cmp++; if (stb_cnt != b0) begin n_bad++; $display("FAIL rd_no_stb: got %0d want 0", stb_cnt - b0); end
  endtask

  task automatic test_wrap();
    int         b0 = stb_cnt;
    logic       a0, a1, a2, a3, a4, a5, a6;
    logic [7:0] d0, d1;
    m_start();
    m_write(8'h44, a0);
    m_write(8'h0F, a1);
    m_write(8'h11, a2);
    m_write(8'h22, a3);
    m_stop();
    n_cmp++; if (stb_log[b0] !== 12'hF11) begin n_bad++; $display("FAIL wrap_stb0: got %h want f11", stb_log[b0]); end
    n_cmp++; if (stb_log[b0+1] !== 12'h022) begin n_bad++; $display("FAIL wrap_stb1: got %h want 022", stb_log[b0+1]); end
    // Pointer byte 1Fh keeps only its low four bits.
    m_start();
    m_write(8'h44, a4);
    m_write(8'h1F, a5);
    m_start();
    m_write(8'h45, a6);
    m_read(1'b0, d0);
    m_read(1'b1, d1);
    m_stop();
    n_cmp++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'b0) begin
      n_bad++; $display("FAIL wrap_acks: got %b want 0000000", {a0, a1, a2, a3, a4, a5, a6});
    end
    n_cmp++; if (d0 !== 8'h11) begin n_bad++; $display("FAIL wrap_rd15: got %h want 11", d0); end
    n_cmp++; if (d1 !== 8'h22) begin n_bad++; $display("FAIL wrap_rd0: got %h want 22", d1); end
  endtask

  task automatic test_bad_addr();
    int   b0 = stb_cnt;
    int   v0 = drv_cnt;
    logic a0, a1;
    m_start();
    m_write(8'h46, a0);
    m_write(8'h00, a1);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_busy: got %b want 0", busy); end
    m_stop();
    n_cmp++; if (a0 !== 1'b1) begin n_bad++; $display("FAIL bad_addr_nack: got %b want 1", a0); end
    n_cmp++; if (a1 !== 1'b1) begin n_bad++; $display("FAIL bad_data_nack: got %b want 1", a1); end
    n_cmp++; if (drv_cnt != v0) begin n_bad++; $display("FAIL bad_drive: got %0d low cycles want 0", drv_cnt - v0); end
    n_cmp++; if (stb_cnt != b0) begin n_bad++; $display("FAIL bad_no_stb: got %0d want 0", stb_cnt - b0); end
  endtask

  task automatic test_partial_stop();
    int         b0 = stb_cnt;
    logic       a0, a1, a2, a3, a4, s;
    logic [7:0] d0;
    m_start();
    m_write(8'h44, a0);
    m_write(8'h05, a1);
    for (int i = 0; i < 4; i++) m_bit(1'b1, s);
    m_stop();
    clk_n(5);
    @(negedge clk);
    n_cmp++; if (stb_cnt != b0) begin n_bad++; $display("FAIL part_no_stb: got %0d want 0", stb_cnt - b0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL part_busy: got %b want 0", busy); end
    m_start();
    m_write(8'h44, a2);
    m_write(8'h05, a3);
    m_start();
    m_write(8'h45, a4);
    m_read(1'b1, d0);
    m_stop();
    n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b0) begin
      n_bad++; $display("FAIL part_acks: got %b want 00000", {a0, a1, a2, a3, a4});
    end
    n_cmp++; if (d0 !== 8'h00) begin n_bad++; $display("FAIL part_mem5: got %h want 00", d0); end
  endtask

  task automatic test_reset_mid_read();
    logic       a0, a1, a2, a3, a4, a5;
    logic [7:0] d0, d;
    int         nz = 0;
    n_cmp++; if (odd_runs != 0) begin n_bad++; $display("FAIL stretch_all: got %0d odd runs want 0", odd_runs); end
    m_start();
    m_write(8'h44, a0);
    m_write(8'h03, a1);
    m_start();
    m_write(8'h45, a2);
    m_read(1'b0, d0);
    // Slave is now stretching and driving the MSB (0) of 5Ah.
    @(negedge clk);
    n_cmp++; if (d0 !== 8'hA5) begin n_bad++; $display("FAIL mid_byte0: got %h want a5", d0); end
    n_cmp++; if (sda_o !== 1'b0) begin n_bad++; $display("FAIL mid_sda_drive: got %b want 0", sda_o); end
    n_cmp++; if (scl_o !== 1'b0) begin n_bad++; $display("FAIL mid_scl_stretch: got %b want 0", scl_o); end
    rst = 1'b1;
    sda_m = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (sda_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_sda: got %b want 1", sda_o); end
    n_cmp++; if (scl_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_scl: got %b want 1", scl_o); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    clk_n(HALF);
    scl_m = 1'b1;
    clk_n(HALF);
    m_start();
    m_write(8'h44, a3);
    m_write(8'h00, a4);
    m_start();
    m_write(8'h45, a5);
    for (int i = 0; i < 16; i++) begin
      m_read(i == 15, d);
      if (d !== 8'h00) nz++;
    end
    m_stop();
    n_cmp++; if ({a3, a4, a5} !== 3'b000) begin n_bad++; $display("FAIL mid_post_acks: got %b want 000", {a3, a4, a5}); end
    n_cmp++; if (nz != 0) begin n_bad++; $display("FAIL mid_mem_clear: got %0d nonzero bytes want 0", nz); end
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL mid_pre_acks: got %b want 000", {a0, a1, a2}); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_bad_addr();
    test_partial_stop();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
